// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared pipeline types, ALU op codes and the all-zero bubble control word.
package pipe_pkg;
  localparam int ALUOP_W = 4;
  localparam logic [4:0] REG_X0 = 5'd0;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_AND = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_XOR = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_SLT = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_SLL = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_SRL = 4'd7;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} stage_state_t;
  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic alu_src;
  } ctrl_t;
  localparam ctrl_t CTRL_BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side inputs and EX-side outputs of the ID/EX register.
interface id_ex_stage_if #(parameter int XLEN = 32, parameter int ALUOP_W = 4);
  logic              if_id_valid;
  logic [XLEN-1:0]   id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic              id_uses_rs1, id_uses_rs2;
  logic              id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_alu_src;
  logic [ALUOP_W-1:0] id_alu_op;
  logic              id_is_halt, ex_flush;
  logic              pc_write, if_id_write, id_ex_valid;
  logic [XLEN-1:0]   id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]        id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic              id_ex_mem_read, id_ex_mem_write, id_ex_reg_write, id_ex_mem_to_reg, id_ex_alu_src;
  logic [ALUOP_W-1:0] id_ex_alu_op;
  logic              is_halted;
  logic [31:0]       stall_count;
  modport master (
    output if_id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
           id_alu_src, id_alu_op, id_is_halt, ex_flush,
    input  pc_write, if_id_write, id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
           id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write,
           id_ex_mem_to_reg, id_ex_alu_src, id_ex_alu_op, is_halted, stall_count
  );
  modport slave (
    input  if_id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_uses_rs1, id_uses_rs2, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
           id_alu_src, id_alu_op, id_is_halt, ex_flush,
    output pc_write, if_id_write, id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
           id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_mem_read, id_ex_mem_write, id_ex_reg_write,
           id_ex_mem_to_reg, id_ex_alu_src, id_ex_alu_op, is_halted, stall_count
  );
endinterface

// File: rtl/id_ex_stage_hazard.sv
// hazard_detect: flags a load in EX whose destination is read by the instruction in ID.
module hazard_detect (
  input  logic       i_if_id_valid,
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_uses_rs1,
  input  logic       i_id_uses_rs2,
  input  logic       i_id_ex_valid,
  input  logic       i_id_ex_mem_read,
  input  logic [4:0] i_id_ex_rd,
  output logic       o_hazard
);
  import pipe_pkg::*;
  logic w_load_in_ex;
  assign w_load_in_ex = i_id_ex_valid & i_id_ex_mem_read & (i_id_ex_rd != REG_X0);
  assign o_hazard = i_if_id_valid & w_load_in_ex &
                    ((i_id_uses_rs1 & (i_id_rs1 == i_id_ex_rd)) | (i_id_uses_rs2 & (i_id_rs2 == i_id_ex_rd)));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubbles and halt drain.
module id_ex_stage import pipe_pkg::*; #(
  parameter int XLEN = 32,
  parameter int ALUOP_W = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input logic clk,
  input logic reset_n,
  id_ex_stage_if.slave bus
);
  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  stage_state_t       r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_valid, r_halted;
  logic [XLEN-1:0]    r_pc, r_d1, r_d2, r_imm;
  logic [4:0]         r_rs1, r_rs2, r_rd;
  ctrl_t              r_ctrl;
  logic [ALUOP_W-1:0] r_alu_op;
  logic [31:0]        r_stalls;
  logic               w_hazard, w_run, w_stall, w_bubble, w_halt_go;
  ctrl_t              w_ctrl;
  hazard_detect u_hazard (
    .i_if_id_valid    (bus.if_id_valid),
    .i_id_rs1         (bus.id_rs1),
    .i_id_rs2         (bus.id_rs2),
    .i_id_uses_rs1    (bus.id_uses_rs1),
    .i_id_uses_rs2    (bus.id_uses_rs2),
    .i_id_ex_valid    (r_valid),
    .i_id_ex_mem_read (r_ctrl.mem_read),
    .i_id_ex_rd       (r_rd),
    .o_hazard         (w_hazard)
  );
  // flush outranks the hazard; outside RUN every cycle is a bubble and ex_flush is moot
  assign w_run     = r_state == RUN;
  assign w_stall   = w_run & ~bus.ex_flush & w_hazard;
  assign w_bubble  = ~w_run | bus.ex_flush | w_hazard;
  assign w_halt_go = ~w_bubble & bus.if_id_valid & bus.id_is_halt;
  assign w_ctrl = '{mem_read:   bus.id_mem_read,
                    mem_write:  bus.id_mem_write,
                    reg_write:  bus.id_reg_write & (bus.id_rd != REG_X0),
                    mem_to_reg: bus.id_mem_to_reg,
                    alu_src:    bus.id_alu_src};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
      r_pc     <= '0;
      r_d1     <= '0;
      r_d2     <= '0;
      r_imm    <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_ctrl   <= CTRL_BUBBLE;
      r_alu_op <= '0;
      r_stalls <= '0;
    end else begin
      r_valid  <= ~w_bubble & bus.if_id_valid;
      r_pc     <= w_bubble ? '0 : bus.id_pc;
      r_d1     <= w_bubble ? '0 : bus.id_rs1_data;
      r_d2     <= w_bubble ? '0 : bus.id_rs2_data;
      r_imm    <= w_bubble ? '0 : bus.id_imm;
      r_rs1    <= w_bubble ? '0 : bus.id_rs1;
      r_rs2    <= w_bubble ? '0 : bus.id_rs2;
      r_rd     <= w_bubble ? '0 : bus.id_rd;
      r_ctrl   <= w_bubble ? CTRL_BUBBLE : w_ctrl;
      r_alu_op <= w_bubble ? '0 : bus.id_alu_op;
      if (w_stall && r_stalls != '1) r_stalls <= r_stalls + 32'd1;
      if (w_halt_go) begin
        r_state <= DRAIN;
        r_cnt   <= CW'(DRAIN_CYCLES - 1);
      end else if (r_state == DRAIN) begin
        if (r_cnt == '0) begin
          r_state  <= HALTED;
          r_halted <= 1'b1;
        end else r_cnt <= r_cnt - 1'b1;
      end
    end
  end
  assign bus.pc_write         = w_run & ~w_stall;
  assign bus.if_id_write      = w_run & ~w_stall;
  assign bus.id_ex_valid      = r_valid;
  assign bus.id_ex_pc         = r_pc;
  assign bus.id_ex_rs1_data   = r_d1;
  assign bus.id_ex_rs2_data   = r_d2;
  assign bus.id_ex_imm        = r_imm;
  assign bus.id_ex_rs1        = r_rs1;
  assign bus.id_ex_rs2        = r_rs2;
  assign bus.id_ex_rd         = r_rd;
  assign bus.id_ex_mem_read   = r_ctrl.mem_read;
  assign bus.id_ex_mem_write  = r_ctrl.mem_write;
  assign bus.id_ex_reg_write  = r_ctrl.reg_write;
  assign bus.id_ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign bus.id_ex_alu_src    = r_ctrl.alu_src;
  assign bus.id_ex_alu_op     = r_alu_op;
  assign bus.is_halted        = r_halted;
  assign bus.stall_count      = r_stalls;
endmodule
